// File: rtl/eth_echo_pkg.sv
// Shared types and helpers for the Ethernet frame echo stage.
// Contents:
//   echo_state_e   - receive / drop / send phase of the store-and-forward loop
//   MAC_ADDR_BYTES - bytes in one MAC address
//   SWAP_BYTES     - bytes covered by the destination/source swap
//   swap_addr()    - buffer address to read for output byte index idx
package eth_echo_pkg;

    typedef enum logic [1:0] {RECV, DROP, SEND} echo_state_e;

    localparam int unsigned MAC_ADDR_BYTES = 6;
    localparam int unsigned SWAP_BYTES     = 12;

    // Output byte idx comes from buffer address swap_addr(idx): the two MAC
    // address fields trade places, everything after them is passed through.
    function automatic int unsigned swap_addr(input int unsigned idx);
        if (idx < MAC_ADDR_BYTES) begin
            return idx + MAC_ADDR_BYTES;
        end else if (idx < SWAP_BYTES) begin
            return idx - MAC_ADDR_BYTES;
        end
        return idx;
    endfunction

endpackage

// File: rtl/eth_echo_ram.sv
// Simple dual-port frame buffer: one synchronous write port, one synchronous
// read port with read enable (read data holds while rd_en is low).
// Ports:
//   clk     - clock
//   wr_en   - write strobe, wr_addr/wr_data - write address and byte
//   rd_en   - read strobe,  rd_addr         - read address
//   rd_data - registered read data, valid the cycle after rd_en
module eth_echo_ram #(
    parameter int unsigned DEPTH = 2048,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/eth_frame_echo.sv
// Store-and-forward AXI-Stream echo: buffers one received frame, swaps the
// destination and source MAC addresses and retransmits it. Runt and oversize
// frames are discarded and counted.
// Ports:
//   i_clk, i_reset_n            - clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tlast   - Rx byte stream in, s_axis_trdy - ready out
//   m_axis_tdata/tvalid/tlast   - Tx byte stream out, m_axis_trdy - ready in
//   o_frame_cnt                 - frames fully echoed (wraps)
//   o_drop_cnt                  - frames dropped (wraps)
module eth_frame_echo
    import eth_echo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BUF_DEPTH  = 2048,
    parameter int unsigned MIN_FRAME  = 14,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_trdy,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_trdy,
    output logic [CNT_WIDTH-1:0]  o_frame_cnt,
    output logic [CNT_WIDTH-1:0]  o_drop_cnt
);

    localparam int unsigned AW = $clog2(BUF_DEPTH);
    localparam int unsigned LW = AW + 1;  // lengths reach BUF_DEPTH itself

    echo_state_e state_q, state_d;
    logic s_trdy_q, s_trdy_d;

    logic [AW-1:0] wr_ptr_q;
    logic [LW-1:0] len_q, rd_idx_q, rx_len;
    logic [CNT_WIDTH-1:0] frame_cnt_q, drop_cnt_q;

    // Read pipeline: stage 1 is the RAM output register, stage 2 the output register.
    logic                  rd_valid_q, rd_last_q;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q, out_last_q;

    logic s_hs, m_hs, rx_last, rx_full, runt, frame_done, load_out, rd_en;
    logic [AW-1:0] rd_addr;

    assign s_hs       = s_axis_tvalid && s_trdy_q;
    assign m_hs       = out_valid_q && m_axis_trdy;
    assign rx_len     = LW'(wr_ptr_q) + LW'(1);
    assign rx_last    = s_hs && s_axis_tlast;
    assign rx_full    = s_hs && !s_axis_tlast && (wr_ptr_q == AW'(BUF_DEPTH - 1));
    assign runt       = rx_len < LW'(MIN_FRAME);
    assign frame_done = m_hs && out_last_q;

    // Stage 2 takes stage 1 when it is empty or draining; stage 1 refills
    // whenever it is empty or being emptied, so a stall propagates back to
    // the RAM read enable and the RAM output simply holds.
    assign load_out = rd_valid_q && (!out_valid_q || m_axis_trdy);
    assign rd_en    = (state_q == SEND) && (rd_idx_q < len_q) && (!rd_valid_q || load_out);
    assign rd_addr  = AW'(swap_addr(32'(rd_idx_q)));

    eth_echo_ram #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (DATA_WIDTH),
        .AW    (AW)
    ) u_ram (
        .clk     (i_clk),
        .wr_en   ((state_q == RECV) && s_hs),
        .wr_addr (wr_ptr_q),
        .wr_data (s_axis_tdata),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // FSM: state register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= RECV;
            s_trdy_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_trdy_q <= s_trdy_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RECV: begin
                if (rx_last) begin
                    state_d = runt ? RECV : SEND;
                end else if (rx_full) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (rx_last) begin
                    state_d = RECV;
                end
            end
            SEND: begin
                if (frame_done) begin
                    state_d = RECV;
                end
            end
            default: state_d = RECV;
        endcase
    end

    // FSM: outputs (ready is registered from the upcoming state)
    always_comb begin
        s_trdy_d = (state_d != SEND);
    end

    // Receive side: write pointer, frame length and drop counter
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q   <= '0;
            len_q      <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (state_q == RECV && s_hs) begin
                wr_ptr_q <= rx_last ? '0 : wr_ptr_q + AW'(1);
                if (rx_last) begin
                    len_q <= rx_len;
                    if (runt) begin
                        drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
                    end
                end
            end else if (state_q == DROP && rx_last) begin
                wr_ptr_q   <= '0;
                drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Transmit side: read index, pipeline stages and frame counter
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd_idx_q    <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            if (rd_en) begin
                rd_idx_q   <= rd_idx_q + LW'(1);
                rd_valid_q <= 1'b1;
                rd_last_q  <= (rd_idx_q == len_q - LW'(1));
            end else if (load_out) begin
                rd_valid_q <= 1'b0;
            end

            if (load_out) begin
                out_data_q  <= rd_data;
                out_valid_q <= 1'b1;
                out_last_q  <= rd_last_q;
            end else if (m_hs) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end

            if (frame_done) begin
                rd_idx_q    <= '0;
                frame_cnt_q <= frame_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign s_axis_trdy   = s_trdy_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tlast  = out_last_q;
    assign o_frame_cnt   = frame_cnt_q;
    assign o_drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_eth_frame_echo.sv
// Self-checking bench for eth_frame_echo: drives frames with optional input
// gaps and random Tx stalls, and compares the echoed stream and counters
// against a frame-level reference (MAC fields swapped, length-based drops).
module tb_eth_frame_echo;

    localparam int MIN_FRAME = 14;
    localparam int BUF_DEPTH = 2048;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic [7:0]  s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_trdy;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_trdy = 1'b0;
    logic [15:0] o_frame_cnt;
    logic [15:0] o_drop_cnt;

    eth_frame_echo #(
        .DATA_WIDTH (8),
        .BUF_DEPTH  (BUF_DEPTH),
        .MIN_FRAME  (MIN_FRAME),
        .CNT_WIDTH  (16)
    ) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_trdy   (s_axis_trdy),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_trdy   (m_axis_trdy),
        .o_frame_cnt   (o_frame_cnt),
        .o_drop_cnt    (o_drop_cnt)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    bit         stall_mode = 1'b0;
    logic [7:0] frame[$];
    logic [7:0] got_q[$];
    bit         got_last_q[$];
    int         first_valid_cyc = -1;
    int         hs_cyc = 0;
    int         exp_frames = 0;
    int         exp_drops = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Tx ready: always high, or a coin flip every cycle when stalling.
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            m_axis_trdy = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: sampled mid-cycle, a handshake seen here completes on the next edge.
    initial begin
        logic [7:0] pd;
        logic       pl;
        bit         pstall;
        pd = '0;
        pl = 1'b0;
        pstall = 1'b0;
        forever begin
            @(negedge i_clk);
            if (!i_reset_n) begin
                pstall = 1'b0;
            end else begin
                if (pstall) begin
                    check("hold_data", int'(m_axis_tdata), int'(pd));
                    check("hold_valid", int'(m_axis_tvalid), 1);
                    check("hold_last", int'(m_axis_tlast), int'(pl));
                end
                if (m_axis_tvalid) begin
                    check("s_trdy_in_send", int'(s_axis_trdy), 0);
                    if (first_valid_cyc < 0) first_valid_cyc = cyc;
                end
                if (m_axis_tvalid && m_axis_trdy) begin
                    got_q.push_back(m_axis_tdata);
                    got_last_q.push_back(m_axis_tlast);
                end
                pstall = m_axis_tvalid && !m_axis_trdy;
                pd = m_axis_tdata;
                pl = m_axis_tlast;
            end
        end
    end

    task automatic send_frame(input bit gaps);
        int n = frame.size();
        bit acc;
        int guard;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                @(posedge i_clk);
                #1;
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = frame[i];
            s_axis_tlast  = (i == n - 1);
            guard = 0;
            do begin
                @(negedge i_clk);
                acc = s_axis_trdy;
                if (acc && i == n - 1) hs_cyc = cyc + 1;
                @(posedge i_clk);
                #1;
                guard++;
            end while (!acc && guard < 5000);
            if (!acc) begin
                check("s_accept", int'(acc), 1);
                break;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic build_frame(input int n, input bit rnd);
        frame.delete();
        for (int i = 0; i < n; i++) frame.push_back(rnd ? 8'($urandom) : 8'(i));
    endtask

    task automatic run_frame(input int n, input bit rnd, input bit gaps, input bit stall);
        logic [7:0] exp[$];
        logic [7:0] t;
        bit echo;
        int guard;
        int m;
        build_frame(n, rnd);
        echo = (n >= MIN_FRAME) && (n <= BUF_DEPTH);
        exp = frame;
        if (echo) begin
            for (int k = 0; k < 6; k++) begin
                t = exp[k];
                exp[k] = exp[k + 6];
                exp[k + 6] = t;
            end
        end
        stall_mode = stall;
        got_q.delete();
        got_last_q.delete();
        first_valid_cyc = -1;
        send_frame(gaps);
        if (echo) begin
            guard = 0;
            while (got_q.size() < n && guard < 20000) begin
                @(posedge i_clk);
                #1;
                guard++;
            end
            check("echo_len", got_q.size(), n);
            m = (got_q.size() < n) ? got_q.size() : n;
            for (int i = 0; i < m; i++) begin
                check("echo_byte", int'(got_q[i]), int'(exp[i]));
                check("echo_last", int'(got_last_q[i]), int'(i == n - 1));
            end
            check("first_valid_latency", first_valid_cyc - hs_cyc, 2);
            exp_frames++;
        end else begin
            repeat (20) begin
                @(posedge i_clk);
                #1;
            end
            check("drop_no_output", got_q.size(), 0);
            exp_drops++;
        end
        repeat (2) begin
            @(posedge i_clk);
            #1;
        end
        check("frame_cnt", int'(o_frame_cnt), exp_frames);
        check("drop_cnt", int'(o_drop_cnt), exp_drops);
        check("s_trdy_idle", int'(s_axis_trdy), 1);
        check("m_tvalid_idle", int'(m_axis_tvalid), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_trdy"}, int'(s_axis_trdy), 0);
        check({tag, "_m_tvalid"}, int'(m_axis_tvalid), 0);
        check({tag, "_m_tdata"}, int'(m_axis_tdata), 0);
        check({tag, "_m_tlast"}, int'(m_axis_tlast), 0);
        check({tag, "_frame_cnt"}, int'(o_frame_cnt), 0);
        check({tag, "_drop_cnt"}, int'(o_drop_cnt), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int n;
        repeat (3) @(posedge i_clk);
        #1;
        check_all_zero("reset");
        #2;
        i_reset_n = 1'b1;
        #1;
        check("trdy_before_edge", int'(s_axis_trdy), 0);
        @(posedge i_clk);
        #1;
        check("trdy_after_edge", int'(s_axis_trdy), 1);

        run_frame(64, 1'b0, 1'b0, 1'b0);    // ramp, no stall
        run_frame(64, 1'b0, 1'b0, 1'b1);    // ramp, random stalls
        run_frame(2049, 1'b0, 1'b0, 1'b0);  // oversize
        run_frame(60, 1'b1, 1'b0, 1'b0);
        run_frame(10, 1'b1, 1'b0, 1'b0);    // runt
        run_frame(14, 1'b1, 1'b0, 1'b0);    // minimum size
        run_frame(BUF_DEPTH, 1'b1, 1'b0, 1'b0);  // exact buffer size

        for (int t = 0; t < 8; t++) begin
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, MIN_FRAME - 1)
                                            : $urandom_range(MIN_FRAME, 300);
            run_frame(n, 1'b1, 1'b1, 1'b1);
        end

        // Reset in the middle of an echo.
        build_frame(100, 1'b1);
        stall_mode = 1'b0;
        got_q.delete();
        got_last_q.delete();
        send_frame(1'b0);
        guard = 0;
        while (got_q.size() < 19 && guard < 1000) begin
            @(posedge i_clk);
            #1;
            guard++;
        end
        check("pre_reset_bytes", (got_q.size() >= 19) ? 1 : 0, 1);
        @(posedge i_clk);
        #2;
        i_reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_frames = 0;
        exp_drops = 0;
        @(posedge i_clk);
        #3;
        i_reset_n = 1'b1;
        @(posedge i_clk);
        #1;
        got_q.delete();
        got_last_q.delete();
        run_frame(64, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
